// File: rtl/mcu_if.sv
// rtl/mcu_if.sv - button/decoder inputs and player-control outputs of the MP3 control unit
interface mcu_if #(
    parameter int SONG_W = 2
);
    logic              play_button;
    logic              next;
    logic              song_done;
    logic              play;
    logic [SONG_W-1:0] song;
    logic              reset_play;

    modport master (
        output play_button,
        output next,
        output song_done,
        input  play,
        input  song,
        input  reset_play
    );

    modport slave (
        input  play_button,
        input  next,
        input  song_done,
        output play,
        output song,
        output reset_play
    );
endinterface

// File: rtl/mcu.sv
// rtl/mcu.sv - MP3 player control unit: play/pause FSM, song index, player-reset pulse
module mcu #(
    parameter int SONG_W = 2
) (
    input  logic clk,
    input  logic reset,
    mcu_if.slave bus
);

    typedef enum logic {
        PAUSED  = 1'b0,
        PLAYING = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SONG_W-1:0] song_q, song_d;
    logic              reset_play_q, reset_play_d;
    logic              play_hist_q, play_hist_d;
    logic              next_hist_q, next_hist_d;

    logic play_press;
    logic next_press;

    // History resets to 1 so a button held through reset release is not a press.
    assign play_press = bus.play_button & ~play_hist_q;
    assign next_press = bus.next & ~next_hist_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= PAUSED;
            song_q       <= '0;
            reset_play_q <= 1'b1;
            play_hist_q  <= 1'b1;
            next_hist_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            song_q       <= song_d;
            reset_play_q <= reset_play_d;
            play_hist_q  <= play_hist_d;
            next_hist_q  <= next_hist_d;
        end
    end

    // song_done beats next beats play; losing presses are consumed, not deferred.
    always_comb begin
        state_d      = state_q;
        song_d       = song_q;
        reset_play_d = 1'b0;
        play_hist_d  = bus.play_button;
        next_hist_d  = bus.next;
        if (bus.song_done) begin
            state_d      = PAUSED;
            reset_play_d = 1'b1;
        end else if (next_press) begin
            song_d       = song_q + 1'b1;
            reset_play_d = 1'b1;
        end else if (play_press) begin
            state_d = (state_q == PLAYING) ? PAUSED : PLAYING;
        end
    end

    always_comb begin
        bus.play       = (state_q == PLAYING);
        bus.song       = song_q;
        bus.reset_play = reset_play_q;
    end

endmodule

// File: tb/tb_mcu.sv
// tb/tb_mcu.sv - scoreboard testbench for the MP3 player control unit
module tb_mcu;

    typedef struct packed {
        logic       play;
        logic [1:0] song;
        logic       reset_play;
        logic [7:0] tag;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   tag_n;
    exp_t exp_q[$];
    event async_ev;

    mcu_if #(.SONG_W(2)) bus ();

    mcu #(.SONG_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string name, input int tag, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b", name, tag, act, req);
        end
    endtask

    task automatic check_song(input int tag, input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL song step %0d: got %0d expected %0d", tag, act, req);
        end
    endtask

    // Monitor: one expected output set per clock edge (or per async reset event).
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or async_ev);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_bit("play", int'(e.tag), bus.play, e.play);
                check_song(int'(e.tag), bus.song, e.song);
                check_bit("reset_play", int'(e.tag), bus.reset_play, e.reset_play);
            end
        end
    end

    task automatic push_exp(input logic ep, input logic [1:0] es, input logic erp);
        exp_t e;
        e.play       = ep;
        e.song       = es;
        e.reset_play = erp;
        e.tag        = tag_n[7:0];
        tag_n++;
        exp_q.push_back(e);
    endtask

    // Drive inputs for one cycle and record what the outputs must be after the next edge.
    task automatic step(input logic rst, input logic pb, input logic nx, input logic sd,
                        input logic ep, input logic [1:0] es, input logic erp);
        @(negedge clk);
        reset           = rst;
        bus.play_button = pb;
        bus.next        = nx;
        bus.song_done   = sd;
        push_exp(ep, es, erp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        tag_n  = 0;
        reset           = 1'b1;
        bus.play_button = 1'b1;
        bus.next        = 1'b0;
        bus.song_done   = 1'b0;
        #1 reset = 1'b0;

        // reset held with play_button high, then release: no toggle
        step(0, 1, 0, 0, 0, 2'd0, 1);
        step(1, 1, 0, 0, 0, 2'd0, 0);
        step(1, 1, 0, 0, 0, 2'd0, 0);
        // play press, hold 10 cycles, release, press again
        step(1, 0, 0, 0, 0, 2'd0, 0);
        step(1, 1, 0, 0, 1, 2'd0, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 1, 2'd0, 0);
        step(1, 0, 0, 0, 1, 2'd0, 0);
        step(1, 1, 0, 0, 0, 2'd0, 0);
        step(1, 0, 0, 0, 0, 2'd0, 0);
        step(1, 1, 0, 0, 1, 2'd0, 0);
        step(1, 0, 0, 0, 1, 2'd0, 0);
        // next while playing: song 1, one-cycle pulse; holding next gives one event
        step(1, 0, 1, 0, 1, 2'd1, 1);
        step(1, 0, 1, 0, 1, 2'd1, 0);
        step(1, 0, 0, 0, 1, 2'd1, 0);
        // song_done while playing, then while paused, then held two cycles
        step(1, 0, 0, 1, 0, 2'd1, 1);
        step(1, 0, 0, 0, 0, 2'd1, 0);
        step(1, 0, 0, 1, 0, 2'd1, 1);
        step(1, 0, 0, 0, 0, 2'd1, 0);
        step(1, 0, 0, 1, 0, 2'd1, 1);
        step(1, 0, 0, 1, 0, 2'd1, 1);
        step(1, 0, 0, 0, 0, 2'd1, 0);
        // advance to song 3 while paused, then wrap
        step(1, 0, 1, 0, 0, 2'd2, 1);
        step(1, 0, 0, 0, 0, 2'd2, 0);
        step(1, 0, 1, 0, 0, 2'd3, 1);
        step(1, 0, 0, 0, 0, 2'd3, 0);
        step(1, 0, 1, 0, 0, 2'd0, 1);
        step(1, 0, 0, 0, 0, 2'd0, 0);
        step(1, 0, 1, 0, 0, 2'd1, 1);
        step(1, 0, 0, 0, 0, 2'd1, 0);
        // collision next + song_done: song kept, paused, single pulse
        step(1, 1, 0, 0, 1, 2'd1, 0);
        step(1, 0, 0, 0, 1, 2'd1, 0);
        step(1, 0, 1, 1, 0, 2'd1, 1);
        step(1, 0, 0, 0, 0, 2'd1, 0);
        step(1, 0, 1, 0, 0, 2'd2, 1);
        step(1, 0, 0, 0, 0, 2'd2, 0);
        // collision play + next: next wins, play press discarded
        step(1, 1, 1, 0, 0, 2'd3, 1);
        step(1, 0, 0, 0, 0, 2'd3, 0);
        step(1, 1, 0, 0, 1, 2'd3, 0);
        step(1, 0, 1, 0, 1, 2'd0, 1);
        step(1, 0, 0, 0, 1, 2'd0, 0);
        step(1, 0, 1, 0, 1, 2'd1, 1);
        step(1, 0, 0, 0, 1, 2'd1, 0);
        step(1, 0, 1, 0, 1, 2'd2, 1);
        step(1, 0, 0, 0, 1, 2'd2, 0);

        // asynchronous reset between edges while playing song 2
        @(posedge clk);
        #2;
        reset = 1'b0;
        push_exp(0, 2'd0, 1);
        -> async_ev;
        step(0, 1, 0, 0, 0, 2'd0, 1);
        step(1, 1, 0, 0, 0, 2'd0, 0);
        step(1, 0, 0, 0, 0, 2'd0, 0);
        step(1, 1, 0, 0, 1, 2'd0, 0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mcu.md
Name: mcu

Overview:
Top-level control unit of the MP3 music player. It turns the user buttons (play/pause, next) and the decoder's end-of-song indication into three player controls:
- a play/pause level,
- a 2-bit song index,
- a one-cycle player-reset pulse.

It sits between the debounced button inputs and the song ROM/decoder datapath.

Parameters:
SONG_W, 2, width of the song index; the index wraps modulo 2**SONG_W (4 songs).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
play_button  input  1  play/pause button level, synchronous to clk, debounced upstream.
next  input  1  next-song button level, synchronous to clk, debounced upstream.
song_done  input  1  decoder end-of-song indication, sampled as a level.
play  output  1  1 = player running, 0 = paused.
song  output  SONG_W  index of the selected song.
reset_play  output  1  one-cycle pulse that rewinds/reinitialises the player.

Behaviour:
- All outputs are registered. Every response appears on the clock edge that samples the event, so outputs change 1 cycle after the input changes.
- While reset = 0 (asynchronous):
  - play = 0, song = 0, reset_play = 1.
  - Both button-history registers = 1.
- First rising clk edge after reset releases: reset_play -> 0 and the state is PAUSED. This gives the player a power-up reset.
- Button edge detection:
  - An internal register holds the previous value of each button.
  - A press is a 0->1 transition, i.e. current = 1 and previous = 0.
  - Holding a button produces exactly one event.
  - Because the history registers reset to 1, a button held high through reset release produces no event.
- State machine: two states, PAUSED (play = 0) and PLAYING (play = 1).
  - play press in PAUSED -> PLAYING.
  - play press in PLAYING -> PAUSED.
- next press:
  - song <= song + 1, wrapping from 3 to 0.
  - reset_play = 1 for exactly one cycle.
  - play is unchanged: the player continues playing, or stays paused, on the new song.
- song_done = 1 on a clock edge:
  - play <= 0.
  - song is unchanged.
  - reset_play = 1 for exactly one cycle.
  - A song_done held high for N cycles gives N consecutive reset_play cycles. It is not edge-detected.
- reset_play default is 0. It is never asserted except in the cases above.
- Priority when events coincide on the same edge: song_done > next > play press.
  - Any event that loses is discarded, not deferred.
  - Its button-history register still updates, so the press is consumed.
- Events arriving while reset_play = 1 are processed normally in that cycle.
- Reset asserted mid-song or mid-pulse: outputs go immediately to their reset values, regardless of clk.

Test Plan:
- Reset: hold reset = 0 with play_button = 1 -> play = 0, song = 0, reset_play = 1. Release reset and clock once -> reset_play = 0, play = 0. No toggle from the held button.
- Play/pause: play_button 1->0->1 -> play = 1 on the edge sampling the 1. Hold play_button = 1 for 10 cycles -> play stays 1. Then 0->1 -> play = 0.
- Next: while playing on song 0, one-cycle next = 1 -> song = 1, reset_play = 1 for one cycle, play stays 1. Four presses from song 3 -> song wraps to 0 on the first press.
- Song done: while playing song 1, one-cycle song_done = 1 -> play = 0, song = 1, reset_play = 1 for exactly one cycle. song_done while already paused -> reset_play pulse, play stays 0.
- Collision: next press and song_done on the same edge -> song unchanged, play = 0, reset_play pulses once.
- Asynchronous reset mid-operation: assert reset between clock edges while play = 1, song = 2 -> outputs 0/0/1 immediately, without waiting for clk.
